// File: rtl/sram_ifmap_pp_if.sv
// sram_ifmap_pp_if: writer/reader bus of the ping-pong ifmap SRAM
interface sram_ifmap_pp_if #(
    parameter int DEPTH = 4096,
    parameter int LANES = 8,
    parameter int BYTES = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DEPTH * BYTES);
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [8*BYTES-1:0] wr_data;
    logic              wr_last;
    logic              rd_en;
    logic              rd_ready;
    logic [BW-1:0]     rd_addr;
    logic              rd_mode;
    logic              rd_done;
    logic [7:0]        rd_data [LANES];
    logic              rd_valid;
    logic [1:0]        bank_full;
    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_mode, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_valid, bank_full
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_mode, rd_done,
        output wr_ready, rd_ready, rd_data, rd_valid, bank_full
    );
endinterface

// File: rtl/sram_ifmap_pp.sv
// sram_ifmap_pp: ping-pong ifmap SRAM, DMA fills one bank while the PE array reads the other
module sram_ifmap_pp #(
    parameter int DEPTH = 4096,
    parameter int LANES = 8,
    parameter int BYTES = 4
) (
    input logic            CLK,
    input logic            RSTN,
    sram_ifmap_pp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DEPTH * BYTES);
    localparam int LB = $clog2(BYTES);
    // byte-addressed storage so gather and linear reads share one lookup per lane
    logic [7:0]    mem [2][DEPTH*BYTES];
    logic [1:0]    full, full_n;
    logic          wb, wb_n, rb, rb_n;
    logic          wr_rdy, rd_rdy;
    logic          wr_acc, wr_fin, rd_acc, rd_rel;
    logic [BW-1:0] byte_addr [LANES];
    logic [7:0]    rd_q [LANES];
    logic          rd_v;

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            full <= full_n;
            wb   <= wb_n;
            rb   <= rb_n;
        end

    // writer and reader always own different banks when both events fire
    always_comb begin
        full_n = full;
        if (wr_fin) full_n[wb] = 1'b1;
        if (rd_rel) full_n[rb] = 1'b0;
        wb_n = wb ^ wr_fin;
        rb_n = rb ^ rd_rel;
    end

    always_comb begin
        wr_rdy = ~full[wb];
        rd_rdy = full[rb];
    end

    assign wr_acc = bus.wr_valid & wr_rdy;
    assign wr_fin = wr_acc & bus.wr_last;
    assign rd_acc = bus.rd_en & rd_rdy;
    assign rd_rel = bus.rd_done & rd_rdy;

    always_ff @(posedge CLK)
        if (wr_acc)
            for (int i = 0; i < BYTES; i++)
                mem[wb][BW'(bus.wr_addr) * BW'(BYTES) + BW'(i)] <= bus.wr_data[8*i +: 8];

    // gather: word index truncated to AW bits gives the mod-DEPTH wrap
    always_comb
        for (int k = 0; k < LANES; k++)
            byte_addr[k] = bus.rd_mode ? bus.rd_addr + BW'(k)
                         : BW'(AW'(int'(bus.rd_addr >> LB) * LANES + k)) * BW'(BYTES)
                           + BW'(bus.rd_addr % BYTES);

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            rd_v <= 1'b0;
            for (int k = 0; k < LANES; k++) rd_q[k] <= 8'h00;
        end else begin
            rd_v <= rd_acc;
            if (rd_acc)
                for (int k = 0; k < LANES; k++) rd_q[k] <= mem[rb][byte_addr[k]];
        end

    assign bus.wr_ready  = wr_rdy;
    assign bus.rd_ready  = rd_rdy;
    assign bus.bank_full = full;
    assign bus.rd_valid  = rd_v;
    assign bus.rd_data   = rd_q;
endmodule

// File: tb/tb_sram_ifmap_pp.sv
// tb_sram_ifmap_pp: table-driven reads with a scoreboard plus bank-swap and reset sequences
module tb_sram_ifmap_pp;
    localparam int DEPTH = 16;
    localparam int LANES = 8;
    localparam int BYTES = 4;
    localparam int NB    = DEPTH * BYTES;
    typedef struct {
        bit          mode;
        int          addr;
        logic [63:0] exp;
    } vec_t;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];
    vec_t tv [6];

    sram_ifmap_pp_if #(.DEPTH(DEPTH), .LANES(LANES), .BYTES(BYTES)) bus ();
    sram_ifmap_pp #(.DEPTH(DEPTH), .LANES(LANES), .BYTES(BYTES)) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_now();
        logic [63:0] v;
        for (int k = 0; k < LANES; k++) v[8*k +: 8] = bus.rd_data[k];
        return v;
    endfunction

    // bank fill pattern: flat byte n of a bank holds base + n
    function automatic logic [63:0] expv(int base, bit mode, int addr);
        logic [63:0] v;
        int n;
        for (int k = 0; k < LANES; k++) begin
            n = mode ? (addr + k) % NB
                     : (((addr / BYTES) * LANES + k) % DEPTH) * BYTES + addr % BYTES;
            v[8*k +: 8] = 8'(base + n);
        end
        return v;
    endfunction

    task automatic mon();
        if (bus.rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid: got 1 expected 0 (no accepted read)");
            end else chk("rd_data", data_now(), sb.pop_front());
        end else if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rd_valid: got 0 expected 1");
            void'(sb.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        mon();
    endtask

    task automatic idle();
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.rd_mode = 0; bus.rd_done = 0;
    endtask

    task automatic wr(int w, logic [31:0] d, bit last);
        bus.wr_valid = 1; bus.wr_addr = 4'(w); bus.wr_data = d; bus.wr_last = last;
        tick();
        bus.wr_valid = 0; bus.wr_last = 0;
    endtask

    task automatic fill(int base);
        for (int w = 0; w < DEPTH; w++)
            wr(w, {8'(base+4*w+3), 8'(base+4*w+2), 8'(base+4*w+1), 8'(base+4*w)}, w == DEPTH-1);
    endtask

    task automatic rd(bit mode, int addr, bit done, logic [63:0] exp);
        bus.rd_en = 1; bus.rd_mode = mode; bus.rd_addr = 6'(addr); bus.rd_done = done;
        sb.push_back(exp);
        tick();
        bus.rd_en = 0; bus.rd_done = 0;
    endtask

    initial begin
        tv[0] = '{0, 1,  64'h1d1915110d090501};
        tv[1] = '{0, 6,  64'h3e3a36322e2a2622};
        tv[2] = '{0, 9,  64'h1d1915110d090501};
        tv[3] = '{1, 61, 64'h04030201003f3e3d};
        tv[4] = '{1, 6,  64'h0d0c0b0a09080706};
        tv[5] = '{1, 0,  64'h0706050403020100};
        idle();
        #12;
        chk("reset wr_ready", bus.wr_ready, 1);
        chk("reset rd_ready", bus.rd_ready, 0);
        chk("reset bank_full", bus.bank_full, 0);
        chk("reset rd_valid", bus.rd_valid, 0);
        chk("reset rd_data", data_now(), 0);
        @(negedge CLK);
        RSTN = 1;
        fill(0);
        chk("bank0 full", bus.bank_full, 1);
        chk("bank0 rd_ready", bus.rd_ready, 1);
        chk("bank1 wr_ready", bus.wr_ready, 1);
        foreach (tv[i]) rd(tv[i].mode, tv[i].addr, 0, tv[i].exp);
        tick();
        chk("rd_valid pulse", bus.rd_valid, 0);
        fill(100);
        chk("both full wr_ready", bus.wr_ready, 0);
        chk("both full bank_full", bus.bank_full, 3);
        wr(0, 32'heeeeeeee, 1);
        chk("ignored write bank_full", bus.bank_full, 3);
        chk("ignored write wr_ready", bus.wr_ready, 0);
        rd(0, 1, 1, tv[0].exp);
        chk("release bank_full", bus.bank_full, 2);
        chk("release wr_ready", bus.wr_ready, 1);
        chk("release rd_ready", bus.rd_ready, 1);
        rd(0, 1, 0, expv(100, 0, 1));
        rd(1, 0, 0, expv(100, 1, 0));
        rd(1, 61, 0, expv(100, 1, 61));
        bus.rd_done = 1;
        tick();
        bus.rd_done = 0;
        chk("empty bank_full", bus.bank_full, 0);
        chk("empty rd_ready", bus.rd_ready, 0);
        bus.rd_en = 1; bus.rd_done = 1; bus.rd_addr = '0;
        tick();
        tick();
        idle();
        chk("ignored read rd_data", data_now(), expv(100, 1, 61));
        chk("ignored done bank_full", bus.bank_full, 0);
        fill(50);
        chk("refill bank_full", bus.bank_full, 1);
        chk("refill rd_ready", bus.rd_ready, 1);
        rd(0, 2, 0, expv(50, 0, 2));
        fill(100);
        chk("pre-reset bank_full", bus.bank_full, 3);
        bus.rd_en = 1; bus.rd_mode = 1; bus.rd_addr = '0;
        @(posedge CLK);
        #1 chk("pre-reset rd_valid", bus.rd_valid, 1);
        #1 RSTN = 0;
        #1;
        chk("async reset wr_ready", bus.wr_ready, 1);
        chk("async reset rd_ready", bus.rd_ready, 0);
        chk("async reset bank_full", bus.bank_full, 0);
        chk("async reset rd_valid", bus.rd_valid, 0);
        chk("async reset rd_data", data_now(), 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1;
        tick();
        tick();
        tick();
        idle();
        chk("post-reset rd_valid", bus.rd_valid, 0);
        chk("post-reset bank_full", bus.bank_full, 0);
        chk("post-reset rd_ready", bus.rd_ready, 0);
        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
